// File: rtl/alu_seq_controller_pkg.sv
// Shared types and encodings for the multi-cycle RV32I sequencing controller.
// Holds the state enum, opcode constants and ALU control encodings.
package alu_seq_controller_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC_R,
      S_EXEC_I,
      S_MEM_ADDR,
      S_MEM_RD,
      S_MEM_WR,
      S_WB_ALU,
      S_WB_MEM,
      S_BRANCH,
      S_TRAP
   } state_e;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;

   // Execution state entered from DECODE; unsupported opcodes trap.
   function automatic state_e decode_state(input logic [6:0] op);
      state_e s;
      case (op)
         OP_R:              s = S_EXEC_R;
         OP_I:              s = S_EXEC_I;
         OP_LOAD, OP_STORE: s = S_MEM_ADDR;
         OP_BRANCH:         s = S_BRANCH;
         default:           s = S_TRAP;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/alu_seq_controller_if.sv
// Memory request/ready handshake between the sequencing controller and memory.
interface alu_seq_controller_if;
   logic mem_req;
   logic mem_we;
   logic i_or_d;
   logic mem_ready;

   modport master (output mem_req, output mem_we, output i_or_d, input mem_ready);
   modport slave  (input mem_req, input mem_we, input i_or_d, output mem_ready);
endinterface

// File: rtl/alu_seq_controller_instret_counter.sv
// 32-bit retired-instruction counter; wraps modulo 2^32.
module instret_counter (
   input  logic        clk,
   input  logic        reset,
   input  logic        inc_i,
   output logic [31:0] count_o
);

   logic [31:0] count_q;
   logic [31:0] count_d;

   assign count_d = inc_i ? count_q + 32'd1 : count_q;

   always_ff @(posedge clk) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/alu_seq_controller.sv
// Multi-cycle sequencer driving ALU control and datapath enables for RV32I.
// Moore outputs, except IRWrite/PCWrite (gated by mem_ready) and PCWriteCond (by zero).
module alu_seq_controller
   import alu_seq_controller_pkg::*;
(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        halt,
   input  logic [6:0]                  opcode,
   input  logic                        zero,
   alu_seq_controller_if.master        mem,
   output logic                        IRWrite,
   output logic                        PCWrite,
   output logic                        PCWriteCond,
   output logic                        ALUSrcA,
   output logic [1:0]                  ALUSrcB,
   output logic [1:0]                  ALUOp,
   output logic                        RegWrite,
   output logic                        MemtoReg,
   output logic                        illegal,
   output logic [31:0]                 instret
);

   state_e state_q, state_d;
   logic   fetch_busy_q, fetch_busy_d;
   logic   fetch_go;
   logic   retire;

   // A fetch already waiting on memory keeps going even if halt rises.
   assign fetch_go = !halt || fetch_busy_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_FETCH;
         fetch_busy_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         fetch_busy_q <= fetch_busy_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      fetch_busy_d = 1'b0;
      case (state_q)
         S_FETCH: begin
            if (fetch_go) begin
               if (mem.mem_ready) state_d = S_DECODE;
               else               fetch_busy_d = 1'b1;
            end
         end
         S_DECODE:   state_d = decode_state(opcode);
         S_EXEC_R:   state_d = S_WB_ALU;
         S_EXEC_I:   state_d = S_WB_ALU;
         S_MEM_ADDR: state_d = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   if (mem.mem_ready) state_d = S_WB_MEM;
         S_MEM_WR:   if (mem.mem_ready) state_d = S_FETCH;
         default:    state_d = S_FETCH;
      endcase
   end

   always_comb begin
      mem.mem_req = 1'b0;
      mem.mem_we  = 1'b0;
      mem.i_or_d  = 1'b0;
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_RS2;
      ALUOp       = ALUOP_ADD;
      RegWrite    = 1'b0;
      MemtoReg    = 1'b0;
      illegal     = 1'b0;
      retire      = 1'b0;
      if (!reset) begin
         case (state_q)
            S_FETCH: begin
               if (fetch_go) begin
                  mem.mem_req = 1'b1;
                  ALUSrcB     = SRCB_FOUR;
                  ALUOp       = ALUOP_ADD;
                  IRWrite     = mem.mem_ready;
                  PCWrite     = mem.mem_ready;
               end
            end
            S_EXEC_R: begin
               ALUSrcA = 1'b1;
               ALUSrcB = SRCB_RS2;
               ALUOp   = ALUOP_FUNCT;
            end
            S_EXEC_I: begin
               ALUSrcA = 1'b1;
               ALUSrcB = SRCB_IMM;
               ALUOp   = ALUOP_FUNCT;
            end
            S_MEM_ADDR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = SRCB_IMM;
               ALUOp   = ALUOP_ADD;
            end
            S_MEM_RD: begin
               mem.mem_req = 1'b1;
               mem.i_or_d  = 1'b1;
            end
            S_MEM_WR: begin
               mem.mem_req = 1'b1;
               mem.mem_we  = 1'b1;
               mem.i_or_d  = 1'b1;
               retire      = mem.mem_ready;
            end
            S_WB_ALU: begin
               RegWrite = 1'b1;
               retire   = 1'b1;
            end
            S_WB_MEM: begin
               RegWrite = 1'b1;
               MemtoReg = 1'b1;
               retire   = 1'b1;
            end
            S_BRANCH: begin
               ALUSrcA     = 1'b1;
               ALUSrcB     = SRCB_RS2;
               ALUOp       = ALUOP_SUB;
               PCWriteCond = zero;
               retire      = 1'b1;
            end
            S_TRAP:  illegal = 1'b1;
            default: ;
         endcase
      end
   end

   instret_counter u_instret (
      .clk     (clk),
      .reset   (reset),
      .inc_i   (retire),
      .count_o (instret)
   );

endmodule

// File: tb/tb_alu_seq_controller.sv
// Scoreboard bench: a memory responder feeds opcodes and wait states, a reference
// model predicts each observable event, and a monitor compares as events appear.
module tb_alu_seq_controller;

   localparam logic [6:0] T_R  = 7'b0110011;
   localparam logic [6:0] T_I  = 7'b0010011;
   localparam logic [6:0] T_LD = 7'b0000011;
   localparam logic [6:0] T_ST = 7'b0100011;
   localparam logic [6:0] T_BR = 7'b1100011;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        halt;
   logic        halt_drv = 1'b0;
   logic        halt_rsp = 1'b1;
   logic [6:0]  opcode = 7'd0;
   logic        zero = 1'b0;
   logic        IRWrite, PCWrite, PCWriteCond, ALUSrcA, RegWrite, MemtoReg, illegal;
   logic [1:0]  ALUSrcB, ALUOp;
   logic [31:0] instret;

   alu_seq_controller_if mif ();

   assign halt = halt_drv | halt_rsp;

   alu_seq_controller dut (
      .clk         (clk),
      .reset       (reset),
      .halt        (halt),
      .opcode      (opcode),
      .zero        (zero),
      .mem         (mif),
      .IRWrite     (IRWrite),
      .PCWrite     (PCWrite),
      .PCWriteCond (PCWriteCond),
      .ALUSrcA     (ALUSrcA),
      .ALUSrcB     (ALUSrcB),
      .ALUOp       (ALUOp),
      .RegWrite    (RegWrite),
      .MemtoReg    (MemtoReg),
      .illegal     (illegal),
      .instret     (instret)
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      bit          fetch;
      logic [6:0]  op;
      bit          z;
      int          wait_c;
   } rsp_t;

   typedef struct {
      logic [13:0] vec;
      logic [31:0] ir;
      int          gap;
   } exp_t;

   rsp_t rsp_q[$];
   exp_t exp_q[$];

   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] m_ret = 32'd0;
   int          carry = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
      end
   endtask

   function automatic logic [13:0] mk(input bit req, input bit we, input bit iod,
                                      input bit irw, input bit pcw, input bit pcc,
                                      input bit sa, input logic [1:0] sb,
                                      input logic [1:0] op, input bit rw,
                                      input bit mtr, input bit ill);
      return {req, we, iod, irw, pcw, pcc, sa, sb, op, rw, mtr, ill};
   endfunction

   function automatic logic [13:0] obs();
      return {mif.mem_req, mif.mem_we, mif.i_or_d, IRWrite, PCWrite, PCWriteCond,
              ALUSrcA, ALUSrcB, ALUOp, RegWrite, MemtoReg, illegal};
   endfunction

   task automatic push_exp(input logic [13:0] v, input int gap);
      exp_t e;
      e.vec = v;
      e.ir  = m_ret;
      e.gap = gap;
      exp_q.push_back(e);
   endtask

   task automatic push_rsp(input bit f, input logic [6:0] op, input bit z, input int w);
      rsp_t r;
      r.fetch  = f;
      r.op     = op;
      r.z      = z;
      r.wait_c = w;
      rsp_q.push_back(r);
   endtask

   // Reference model: the events one instruction produces, from the architectural rules.
   task automatic issue(input logic [6:0] op, input bit z, input int fw, input int dw,
                        input bit first);
      push_rsp(1'b1, op, z, fw);
      push_exp(mk(1,0,0,1,1,0,0,2'b01,2'b00,0,0,0), first ? -1 : carry + fw);
      if (op == T_R || op == T_I) begin
         push_exp(mk(0,0,0,0,0,0,1,(op == T_R) ? 2'b00 : 2'b10,2'b10,0,0,0), 0);
         push_exp(mk(0,0,0,0,0,0,0,2'b00,2'b00,1,0,0), 0);
         m_ret++;
         carry = 4;
      end else if (op == T_LD) begin
         push_exp(mk(0,0,0,0,0,0,1,2'b10,2'b00,0,0,0), 0);
         push_rsp(1'b0, 7'd0, 1'b0, dw);
         push_exp(mk(1,0,1,0,0,0,0,2'b00,2'b00,0,0,0), 0);
         push_exp(mk(0,0,0,0,0,0,0,2'b00,2'b00,1,1,0), 0);
         m_ret++;
         carry = 5 + dw;
      end else if (op == T_ST) begin
         push_exp(mk(0,0,0,0,0,0,1,2'b10,2'b00,0,0,0), 0);
         push_rsp(1'b0, 7'd0, 1'b0, dw);
         push_exp(mk(1,1,1,0,0,0,0,2'b00,2'b00,0,0,0), 0);
         m_ret++;
         carry = 4 + dw;
      end else if (op == T_BR) begin
         push_exp(mk(0,0,0,0,0,z,1,2'b00,2'b01,0,0,0), 0);
         m_ret++;
         carry = 3;
      end else begin
         push_exp(mk(0,0,0,0,0,0,0,2'b00,2'b00,0,0,1), 0);
         carry = 3;
      end
   endtask

   task automatic wait_drain(input int maxc);
      for (int i = 0; i < maxc && exp_q.size() != 0; i++) @(negedge clk);
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
      repeat (4) @(negedge clk);
   endtask

   // Memory responder: serves requests in order with the queued wait counts.
   initial begin : responder
      rsp_t cur;
      bit   active;
      bit   anyf;
      int   cnt;
      active = 1'b0;
      cnt = 0;
      cur.fetch = 1'b0;
      cur.op = 7'd0;
      cur.z = 1'b0;
      cur.wait_c = 0;
      mif.mem_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            active = 1'b0;
            mif.mem_ready = 1'b0;
         end else begin
            if (active && mif.mem_ready) begin
               active = 1'b0;
               if (cur.fetch) begin
                  opcode = cur.op;
                  zero   = cur.z;
               end
            end
            mif.mem_ready = 1'b0;
            if (!active && mif.mem_req) begin
               if (rsp_q.size() == 0) begin
                  chk("req_without_work", 64'(mif.mem_req), 64'd0);
               end else begin
                  cur = rsp_q.pop_front();
                  chk("req_kind_i_or_d", 64'(mif.i_or_d), 64'(!cur.fetch));
                  active = 1'b1;
                  cnt = cur.wait_c;
               end
            end
            if (active) begin
               if (cnt == 0) mif.mem_ready = 1'b1;
               else cnt--;
            end
         end
         anyf = active && cur.fetch;
         foreach (rsp_q[i]) if (rsp_q[i].fetch) anyf = 1'b1;
         halt_rsp = !anyf;
      end
   end

   // Monitor: pops the next expected event whenever the DUT shows one.
   initial begin : monitor
      exp_t        e;
      logic [13:0] v;
      int          cyc;
      int          last_f;
      bit          p_wait;
      logic [13:0] p_v;
      cyc = 0;
      last_f = 0;
      p_wait = 1'b0;
      p_v = '0;
      forever begin
         @(negedge clk);
         #2;
         cyc++;
         v = obs();
         if (reset) begin
            exp_q.delete();
            p_wait = 1'b0;
         end else begin
            if (p_wait) begin
               chk("req_held_stable", 64'({mif.mem_req, mif.mem_we, mif.i_or_d}),
                   64'(p_v[13:11]));
            end
            if ((mif.mem_req && mif.mem_ready) || ALUSrcA || RegWrite || illegal) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_event", 64'(v), 64'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("event_outputs", 64'(v), 64'(e.vec));
                  chk("event_instret", 64'(instret), 64'(e.ir));
                  if (e.vec[10]) begin
                     if (e.gap >= 0) chk("fetch_gap_cycles", 64'(cyc - last_f), 64'(e.gap));
                     last_f = cyc;
                  end
               end
            end else if (!mif.mem_req) begin
               chk("quiet_outputs", 64'(v), 64'd0);
            end else begin
               chk("wait_no_irw_pcw", 64'({IRWrite, PCWrite}), 64'd0);
            end
            p_wait = mif.mem_req && !mif.mem_ready;
            p_v = v;
         end
      end
   end

   initial begin : driver
      int          idx;
      logic [6:0]  op;
      repeat (3) @(negedge clk);
      #3;
      chk("reset_outputs", 64'(obs()), 64'd0);
      chk("reset_instret", 64'(instret), 64'd0);
      #1 reset = 1'b0;

      // R-type alone, then a directed mix including a load with two wait states.
      @(negedge clk); #1;
      issue(T_R, 1'b0, 0, 0, 1'b1);
      wait_drain(100);
      chk("instret_after_r", 64'(instret), 64'd1);
      @(negedge clk); #1;
      issue(T_R,  1'b0, 0, 0, 1'b1);
      issue(T_LD, 1'b0, 0, 2, 1'b0);
      issue(T_R,  1'b0, 0, 0, 1'b0);
      issue(T_BR, 1'b1, 0, 0, 1'b0);
      issue(T_BR, 1'b0, 1, 0, 1'b0);
      issue(7'b1111111, 1'b0, 0, 0, 1'b0);
      issue(T_I,  1'b0, 0, 0, 1'b0);
      issue(T_ST, 1'b0, 2, 1, 1'b0);
      issue(T_I,  1'b0, 0, 0, 1'b0);
      wait_drain(300);
      chk("instret_after_mix", 64'(instret), 64'(m_ret));

      // Halt held in FETCH keeps memory idle.
      @(negedge clk); #1;
      halt_drv = 1'b1;
      issue(T_I, 1'b0, 0, 0, 1'b1);
      repeat (5) begin
         @(negedge clk); #3;
         chk("halt_no_req", 64'(mif.mem_req), 64'd0);
      end
      halt_drv = 1'b0;
      wait_drain(100);

      // Halt rising while a fetch waits lets that fetch and its instruction finish.
      @(negedge clk); #1;
      issue(T_R, 1'b0, 3, 0, 1'b1);
      for (int i = 0; i < 20 && !mif.mem_req; i++) begin @(negedge clk); #3; end
      chk("fetch_req_seen", 64'(mif.mem_req), 64'd1);
      @(negedge clk); #1;
      halt_drv = 1'b1;
      wait_drain(100);
      chk("instret_mid_halt", 64'(instret), 64'(m_ret));
      halt_drv = 1'b0;

      // Counter wrap: preload all-ones, then retire twice.
      @(negedge clk); #1;
      force dut.u_instret.count_d = 32'hFFFF_FFFF;
      @(negedge clk); #1;
      release dut.u_instret.count_d;
      m_ret = 32'hFFFF_FFFF;
      #2;
      chk("instret_preload", 64'(instret), 64'hFFFF_FFFF);
      issue(T_R, 1'b0, 0, 0, 1'b1);
      issue(T_BR, 1'b0, 0, 0, 1'b0);
      wait_drain(100);
      chk("instret_wrap", 64'(instret), 64'd1);

      // Randomized batches.
      for (int b = 0; b < 3; b++) begin
         @(negedge clk); #1;
         for (int n = 0; n < 40; n++) begin
            idx = int'($urandom_range(0, 5));
            case (idx)
               0: op = T_R;
               1: op = T_I;
               2: op = T_LD;
               3: op = T_ST;
               4: op = T_BR;
               default: op = 7'($urandom_range(0, 127));
            endcase
            issue(op, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 3)), n == 0);
         end
         wait_drain(2000);
      end
      chk("instret_after_random", 64'(instret), 64'(m_ret));

      // Reset during a stalled store write.
      @(negedge clk); #1;
      issue(T_ST, 1'b0, 0, 20, 1'b1);
      for (int i = 0; i < 30 && !mif.mem_we; i++) begin @(negedge clk); #3; end
      chk("store_req_seen", 64'(mif.mem_we), 64'd1);
      @(negedge clk); #1;
      reset = 1'b1;
      @(negedge clk); #3;
      chk("midreset_outputs", 64'(obs()), 64'd0);
      chk("midreset_instret", 64'(instret), 64'd0);
      #1 reset = 1'b0;
      m_ret = 32'd0;
      repeat (3) @(negedge clk);
      #3;
      chk("postreset_idle_req", 64'(mif.mem_req), 64'd0);
      #1;
      issue(T_R, 1'b0, 0, 0, 1'b1);
      wait_drain(100);
      chk("postreset_instret", 64'(instret), 64'd1);
      chk("rsp_queue_empty", 64'(rsp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
